// File: rtl/audio_stream_pkg.sv
// Shared types for the packetised audio sample stream: default widths,
// the per-frame result layout and the frame sink state encoding.
package audio_stream_pkg;

    localparam int SAMPLE_W_DEF  = 16;
    localparam int MAX_BEATS_DEF = 1024;
    localparam int CNT_W_DEF     = $clog2(MAX_BEATS_DEF + 1);
    localparam int ACC_W_DEF     = 2 * SAMPLE_W_DEF + $clog2(MAX_BEATS_DEF);

    // Result layout at the default widths, for consumers of the stats beat.
    typedef struct packed {
        logic [SAMPLE_W_DEF-1:0] peak;
        logic [ACC_W_DEF-1:0]    energy;
        logic [CNT_W_DEF-1:0]    count;
        logic                    overflow;
    } frame_stats_t;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/sample_sq_stage.sv
// Registered magnitude and square of a signed sample, with a valid bit
// travelling alongside and a synchronous clear.
module sample_sq_stage #(
    parameter int SAMPLE_W = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [SAMPLE_W-1:0]   data,
    output logic                  out_valid,
    output logic [SAMPLE_W-1:0]   mag,
    output logic [2*SAMPLE_W-1:0] sq
);

    logic [SAMPLE_W-1:0]   abs_val;
    logic [2*SAMPLE_W-1:0] abs_wide;

    // Negating the most negative value wraps to 2^(W-1), which is exact as unsigned.
    assign abs_val  = data[SAMPLE_W-1] ? (~data + 1'b1) : data;
    assign abs_wide = {{SAMPLE_W{1'b0}}, abs_val};

    always_ff @(posedge clk) begin
        if (clr) begin
            out_valid <= 1'b0;
            mag       <= '0;
            sq        <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                mag <= abs_val;
                sq  <= abs_wide * abs_wide;
            end
        end
    end

endmodule

// File: rtl/frame_peak_energy.sv
// Frame sink: accumulates peak magnitude, energy and beat count per frame
// and emits one registered result beat per frame.
module frame_peak_energy
    import audio_stream_pkg::*;
#(
    parameter int SAMPLE_W  = SAMPLE_W_DEF,
    parameter int MAX_BEATS = MAX_BEATS_DEF,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1),
    parameter int ACC_W     = 2 * SAMPLE_W + $clog2(MAX_BEATS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                s_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [SAMPLE_W-1:0] m_peak,
    output logic [ACC_W-1:0]    m_energy,
    output logic [CNT_W-1:0]    m_count,
    output logic                m_overflow,
    output state_t              fsm_state
);

    // Handshake: a beat moves on a channel at the rising edge where valid and
    // ready are both high; valid holds its payload stable until that edge.

    state_t state, next_state;

    logic [CNT_W-1:0]      beat_cnt;
    logic                  accept, at_limit, close, ovf_close, handshake;
    logic                  pipe_valid;
    logic [SAMPLE_W-1:0]   pipe_mag;
    logic [2*SAMPLE_W-1:0] pipe_sq;
    logic [SAMPLE_W-1:0]   acc_peak;
    logic [ACC_W-1:0]      acc_energy;
    logic [CNT_W-1:0]      acc_count;
    logic                  acc_ovf;

    assign s_ready   = rst_n && (state == ACCUM);
    assign accept    = s_valid && s_ready;
    assign at_limit  = (beat_cnt == CNT_W'(MAX_BEATS - 1));
    assign close     = accept && (s_last || at_limit);
    assign ovf_close = accept && at_limit && !s_last;
    assign handshake = m_valid && m_ready;
    assign fsm_state = state;

    always_comb begin
        next_state = state;
        case (state)
            ACCUM:   if (close) next_state = DRAIN;
            DRAIN:   next_state = OUT;
            OUT:     if (handshake) next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ACCUM;
        else        state <= next_state;
    end

    sample_sq_stage #(.SAMPLE_W(SAMPLE_W)) u_sq (
        .clk       (clk),
        .clr       (!rst_n),
        .in_valid  (accept),
        .data      (s_data),
        .out_valid (pipe_valid),
        .mag       (pipe_mag),
        .sq        (pipe_sq)
    );

    // Beats accepted so far in the open frame; decides the forced close.
    always_ff @(posedge clk) begin
        if (!rst_n || close) beat_cnt <= '0;
        else if (accept)     beat_cnt <= beat_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || handshake) begin
            acc_peak   <= '0;
            acc_energy <= '0;
            acc_count  <= '0;
            acc_ovf    <= 1'b0;
        end else begin
            if (ovf_close) acc_ovf <= 1'b1;
            if (pipe_valid) begin
                if (pipe_mag > acc_peak) acc_peak <= pipe_mag;
                acc_energy <= acc_energy + ACC_W'(pipe_sq);
                acc_count  <= acc_count + 1'b1;
            end
        end
    end

    // The first OUT cycle waits for stage 2 to settle, then the result is captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            m_peak     <= '0;
            m_energy   <= '0;
            m_count    <= '0;
            m_overflow <= 1'b0;
        end else begin
            m_valid <= (state == OUT) && (next_state == OUT);
            if (state == OUT && !m_valid) begin
                m_peak     <= acc_peak;
                m_energy   <= acc_energy;
                m_count    <= acc_count;
                m_overflow <= acc_ovf;
            end
        end
    end

endmodule
